// File: rtl/marx_rr_allocator.sv
// ---------------------------------------------------------------------------
// marx_rr_allocator
//   Round-robin allocator behind the marx_arbiter_if "arbiter" modport.
//
//   Each cycle it hands up to NOUT free shared APUs (FPU/LNU) to distinct
//   pending core requests. The search starts at a rotating priority pointer.
//   Grants are combinational, so a request is acked in the cycle it is seen.
//
//   Optional feature, selected by the macro MARX_ALLOC_AGE_EN:
//     When it is defined, each requester has an age counter that saturates
//     at MAX_WAIT. Requesters whose age has reached MAX_WAIT are served
//     first. When it is not defined, the block is a pure round-robin
//     allocator and has no age registers.
//
// Ports
//   clk_i    in   1          clock; all state changes on the rising edge
//   rst_i    in   1          asynchronous active-high reset
//   req_d    in   NIN        requester i wants a resource; held until acked
//   avail_d  in   NOUT       resource j can accept an operation this cycle
//   ack_d    out  NIN        requester i granted this cycle
//   assid_d  out  NOUT*NIN2  requester index routed to resource j
//   alloc_d  out  NOUT       resource j allocated this cycle
// ---------------------------------------------------------------------------
module marx_rr_allocator #(
  parameter int NIN      = 8,
  parameter int NOUT     = 2,
  parameter int NIN2     = $clog2(NIN),
  parameter int MAX_WAIT = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NIN-1:0]             req_d,
  input  logic [NOUT-1:0]            avail_d,
  output logic [NIN-1:0]             ack_d,
  output logic [NOUT-1:0][NIN2-1:0]  assid_d,
  output logic [NOUT-1:0]            alloc_d
);

  // Reject configurations the index and age logic cannot represent.
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("marx_rr_allocator: MAX_WAIT must be at least 1");
  end
  if ((NIN2 < 1) || ((1 << NIN2) < NIN)) begin : g_bad_nin2
    $error("marx_rr_allocator: NIN2 too narrow for NIN");
  end

`ifdef MARX_ALLOC_AGE_EN
  // The first pass serves only old requesters. The second pass serves
  // everyone still waiting.
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic [NIN2-1:0]             ptr_q, ptr_d;
  logic [NPASS-1:0][NIN-1:0]   pass_mask;
  logic [NIN-1:0]              granted;
  logic [NOUT-1:0]             alloc_c;
  logic [NOUT-1:0][NIN2-1:0]   assid_c;
  logic [NIN2-1:0]             last_idx;
  logic                        any_grant;
  logic [NIN2-1:0]             idx;

  // Step k positions from base in circular order. The wrap is explicit, so
  // NIN does not have to be a power of two.
  function automatic logic [NIN2-1:0] circ(input logic [NIN2-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NIN) s = s - NIN;
    return NIN2'(s);
  endfunction

`ifdef MARX_ALLOC_AGE_EN
  localparam int AW = $clog2(MAX_WAIT + 1);

  logic [NIN-1:0][AW-1:0] age_q, age_d;
  logic [NIN-1:0]         old_c;

  for (genvar gi = 0; gi < NIN; gi++) begin : g_age
    assign old_c[gi] = (age_q[gi] == AW'(MAX_WAIT));

    always_comb begin
      age_d[gi] = '0;
      if (req_d[gi] && !granted[gi]) begin
        age_d[gi] = old_c[gi] ? age_q[gi] : age_q[gi] + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) age_q[gi] <= '0;
      else       age_q[gi] <= age_d[gi];
    end
  end

  assign pass_mask[0] = req_d & old_c;
  assign pass_mask[1] = req_d;
`else
  assign pass_mask[0] = req_d;
`endif

  // Visit resources in ascending order. Each available, still-unallocated
  // resource takes the first eligible requester found from ptr. The last
  // grant made in this sequence sets where the pointer moves next.
  always_comb begin
    granted   = '0;
    alloc_c   = '0;
    assid_c   = '0;
    last_idx  = ptr_q;
    any_grant = 1'b0;
    idx       = '0;
    for (int p = 0; p < NPASS; p++) begin
      for (int j = 0; j < NOUT; j++) begin
        for (int k = 0; k < NIN; k++) begin
          idx = circ(ptr_q, k);
          if (avail_d[j] && !alloc_c[j] && pass_mask[p][idx] && !granted[idx]) begin
            granted[idx] = 1'b1;
            alloc_c[j]   = 1'b1;
            assid_c[j]   = idx;
            last_idx     = idx;
            any_grant    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (last_idx == NIN2'(NIN - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // While reset is asserted the outputs are forced quiet, even mid-cycle.
  assign ack_d   = rst_i ? '0 : granted;
  assign alloc_d = rst_i ? '0 : alloc_c;
  assign assid_d = rst_i ? '0 : assid_c;

endmodule

// File: tb/tb_marx_rr_allocator.sv
module tb_marx_rr_allocator;

  localparam int NIN      = 4;
  localparam int NOUT     = 2;
  localparam int NIN2     = 2;
  localparam int MAX_WAIT = 4;

  logic                      clk_i;
  logic                      rst_i;
  logic [NIN-1:0]            req_d;
  logic [NOUT-1:0]           avail_d;
  logic [NIN-1:0]            ack_d;
  logic [NOUT-1:0][NIN2-1:0] assid_d;
  logic [NOUT-1:0]           alloc_d;

  int total = 0;
  int bad   = 0;

  marx_rr_allocator #(
    .NIN(NIN), .NOUT(NOUT), .NIN2(NIN2), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_d   (req_d),
    .avail_d (avail_d),
    .ack_d   (ack_d),
    .assid_d (assid_d),
    .alloc_d (alloc_d)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] avail;
    logic [3:0] ack;
    logic [1:0] alloc;
    logic [3:0] assid;   // {assid[1], assid[0]}
  } vec_t;

  vec_t vecs[14];

  // Drive just after the rising edge, then compare on the falling edge.
  task automatic step(input string name, input logic rst, input logic [3:0] req,
                      input logic [1:0] avail, input logic [3:0] ea,
                      input logic [1:0] eal, input logic [3:0] eas);
    @(posedge clk_i);
    #1;
    rst_i   = rst;
    req_d   = req;
    avail_d = avail;
    @(negedge clk_i);
    $display("%s rst=%b req=%b avail=%b ack=%b alloc=%b assid=%h",
             name, rst, req, avail, ack_d, alloc_d, assid_d);
    total++;
    if (ack_d !== ea) begin
      bad++;
      $display("FAIL %s ack: got=%b want=%b", name, ack_d, ea);
    end
    total++;
    if (alloc_d !== eal) begin
      bad++;
      $display("FAIL %s alloc: got=%b want=%b", name, alloc_d, eal);
    end
    total++;
    if (assid_d !== eas) begin
      bad++;
      $display("FAIL %s assid: got=%h want=%h", name, assid_d, eas);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    req_d   = '0;
    avail_d = '0;

    //           rst   req      avail  ack      alloc  assid
    vecs[0]  = '{1'b1, 4'b1111, 2'b11, 4'b0000, 2'b00, 4'h0};  // reset holds outputs low
    vecs[1]  = '{1'b0, 4'b1111, 2'b11, 4'b0011, 2'b11, 4'h4};  // ptr 0 -> {1,0}, ptr->2
    vecs[2]  = '{1'b0, 4'b1111, 2'b11, 4'b1100, 2'b11, 4'hE};  // ptr 2 -> {3,2}, ptr->0
    vecs[3]  = '{1'b0, 4'b0110, 2'b01, 4'b0010, 2'b01, 4'h1};  // ptr 0 -> r1 on j0, ptr->2
    vecs[4]  = '{1'b0, 4'b1010, 2'b10, 4'b1000, 2'b10, 4'hC};  // partial avail, ptr->0
    vecs[5]  = '{1'b0, 4'b0100, 2'b10, 4'b0100, 2'b10, 4'h8};  // r2 on j1, ptr->3
    vecs[6]  = '{1'b0, 4'b1001, 2'b11, 4'b1001, 2'b11, 4'h3};  // wrap: j0=3, j1=0, ptr->1
    vecs[7]  = '{1'b0, 4'b1111, 2'b00, 4'b0000, 2'b00, 4'h0};  // no avail, ptr holds
    vecs[8]  = '{1'b0, 4'b0000, 2'b11, 4'b0000, 2'b00, 4'h0};  // no req, ptr holds
    vecs[9]  = '{1'b0, 4'b1111, 2'b01, 4'b0010, 2'b01, 4'h1};  // ptr still 1, ptr->2
    vecs[10] = '{1'b0, 4'b0001, 2'b11, 4'b0001, 2'b01, 4'h0};  // surplus j1 unused, ptr->1
    vecs[11] = '{1'b0, 4'b0100, 2'b11, 4'b0100, 2'b01, 4'h2};  // ptr->3
    vecs[12] = '{1'b0, 4'b1111, 2'b11, 4'b1001, 2'b11, 4'h3};  // j0=3, j1=0, ptr->1
    vecs[13] = '{1'b0, 4'b1111, 2'b11, 4'b0110, 2'b11, 4'h9};  // j0=1, j1=2

    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].avail,
           vecs[i].ack, vecs[i].alloc, vecs[i].assid);
    end

    // Requester 0 waits four cycles with ptr parked at 1.
    step("age_rst",    1'b1, 4'b0001, 2'b01, 4'b0000, 2'b00, 4'h0);
    step("age_setptr", 1'b0, 4'b0001, 2'b01, 4'b0001, 2'b01, 4'h0);  // ptr->1
    for (int c = 0; c < 4; c++) begin
      step($sformatf("age_wait%0d", c), 1'b0, 4'b0001, 2'b00, 4'b0000, 2'b00, 4'h0);
    end
`ifdef MARX_ALLOC_AGE_EN
    step("age_priority", 1'b0, 4'b0011, 2'b01, 4'b0001, 2'b01, 4'h0);
`else
    step("age_priority", 1'b0, 4'b0011, 2'b01, 4'b0010, 2'b01, 4'h1);
`endif

    // A reset in the middle of a wait clears the age. The shortened wait
    // must then not win over the round-robin order.
    step("mid_rst0", 1'b1, 4'b1000, 2'b01, 4'b0000, 2'b00, 4'h0);
    for (int c = 0; c < 3; c++) begin
      step($sformatf("mid_wait%0d", c), 1'b0, 4'b1000, 2'b00, 4'b0000, 2'b00, 4'h0);
    end
    step("mid_rst1", 1'b1, 4'b1000, 2'b01, 4'b0000, 2'b00, 4'h0);
    for (int c = 0; c < 2; c++) begin
      step($sformatf("post_wait%0d", c), 1'b0, 4'b1000, 2'b00, 4'b0000, 2'b00, 4'h0);
    end
    step("age_cleared", 1'b0, 4'b1001, 2'b01, 4'b0001, 2'b01, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
